// File: rtl/col_hist_accum.sv
// Column-projection histogram: clears a 256x8 dual-port RAM, counts hit pixels per
// column by read-modify-write, then scans the RAM for the peak column and total.
module col_hist_accum #(
    parameter logic [7:0] MIN_PEAK   = 8'd4,
    parameter int         RAM_RD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sof,
    input  logic        eof,
    input  logic        pix_valid,
    input  logic [7:0]  pix_x,
    input  logic        pix_hit,
    output logic        busy,
    output logic        result_valid,
    output logic [7:0]  peak_x,
    output logic [7:0]  peak_cnt,
    output logic [15:0] col_total,
    output logic        found,
    output logic        ram_cea,
    output logic        ram_wrea,
    output logic [7:0]  ram_ada,
    output logic [7:0]  ram_dina,
    output logic        ram_ceb,
    output logic [7:0]  ram_adb,
    input  logic [7:0]  ram_doutb
);
    typedef enum logic [2:0] {IDLE, CLEAR, ACCUM, DRAIN, SCAN, DONE} state_t;

    localparam logic [8:0] LAT      = 9'(RAM_RD_LAT);
    localparam logic [7:0] LAT8     = 8'(RAM_RD_LAT);
    localparam logic [8:0] SCAN_END = 9'd255 + LAT;

    state_t      state;
    logic        p1_valid, p2_valid;
    logic [7:0]  p1_x, p2_x;
    logic        old_we;
    logic [7:0]  old_ad, old_din;
    logic        drain_cnt;
    logic [8:0]  scan_cnt;
    logic [7:0]  max_cnt, max_x;
    logic [15:0] sum;

    logic        accept;
    logic [7:0]  cur_val, nv, scan_idx, new_max, new_x;
    logic [15:0] new_sum;
    logic        gt;

    always_comb begin
        accept = (state == ACCUM) && pix_valid && pix_hit && !eof && !sof;
        // The write on port A now and the one before it both land at or after
        // the edge that captured ram_doutb, so either may be newer than the RAM data.
        if (ram_wrea && ram_ada == p2_x)
            cur_val = ram_dina;
        else if (old_we && old_ad == p2_x)
            cur_val = old_din;
        else
            cur_val = ram_doutb;
        nv       = (cur_val == 8'hFF) ? 8'hFF : cur_val + 8'd1;
        scan_idx = scan_cnt[7:0] - LAT8;
        gt       = ram_doutb > max_cnt;
        new_max  = gt ? ram_doutb : max_cnt;
        new_x    = gt ? scan_idx : max_x;
        new_sum  = sum + {8'd0, ram_doutb};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            p1_valid     <= 1'b0;
            p2_valid     <= 1'b0;
            p1_x         <= 8'd0;
            p2_x         <= 8'd0;
            old_we       <= 1'b0;
            old_ad       <= 8'd0;
            old_din      <= 8'd0;
            drain_cnt    <= 1'b0;
            scan_cnt     <= 9'd0;
            max_cnt      <= 8'd0;
            max_x        <= 8'd0;
            sum          <= 16'd0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            peak_x       <= 8'd0;
            peak_cnt     <= 8'd0;
            col_total    <= 16'd0;
            found        <= 1'b0;
            ram_cea      <= 1'b0;
            ram_wrea     <= 1'b0;
            ram_ada      <= 8'd0;
            ram_dina     <= 8'd0;
            ram_ceb      <= 1'b0;
            ram_adb      <= 8'd0;
        end else begin
            p1_valid     <= accept;
            if (accept)
                p1_x <= pix_x;
            p2_valid     <= p1_valid && !sof;
            p2_x         <= p1_x;
            old_we       <= ram_cea && ram_wrea;
            old_ad       <= ram_ada;
            old_din      <= ram_dina;
            result_valid <= 1'b0;
            ram_ceb      <= 1'b0;

            // Port A: clear sweep has priority, otherwise the S2 write-back.
            if (sof) begin
                ram_cea  <= 1'b1;
                ram_wrea <= 1'b1;
                ram_ada  <= 8'd0;
                ram_dina <= 8'd0;
            end else if (state == CLEAR) begin
                if (ram_ada == 8'hFF) begin
                    ram_cea  <= 1'b0;
                    ram_wrea <= 1'b0;
                end else begin
                    ram_ada <= ram_ada + 8'd1;
                end
            end else if (p2_valid) begin
                ram_cea  <= 1'b1;
                ram_wrea <= 1'b1;
                ram_ada  <= p2_x;
                ram_dina <= nv;
            end else begin
                ram_cea  <= 1'b0;
                ram_wrea <= 1'b0;
            end

            if (sof) begin
                state <= CLEAR;
                busy  <= 1'b1;
            end else begin
                case (state)
                    IDLE: ;
                    CLEAR: begin
                        if (ram_ada == 8'hFF) begin
                            state <= ACCUM;
                            busy  <= 1'b0;
                        end
                    end
                    ACCUM: begin
                        if (eof) begin
                            state     <= DRAIN;
                            busy      <= 1'b1;
                            drain_cnt <= 1'b0;
                        end else if (accept) begin
                            ram_ceb <= 1'b1;
                            ram_adb <= pix_x;
                        end
                    end
                    DRAIN: begin
                        if (drain_cnt) begin
                            state    <= SCAN;
                            ram_ceb  <= 1'b1;
                            ram_adb  <= 8'd0;
                            scan_cnt <= 9'd0;
                            max_cnt  <= 8'd0;
                            max_x    <= 8'd0;
                            sum      <= 16'd0;
                        end else begin
                            drain_cnt <= 1'b1;
                        end
                    end
                    SCAN: begin
                        scan_cnt <= scan_cnt + 9'd1;
                        if (scan_cnt < 9'd255) begin
                            ram_ceb <= 1'b1;
                            ram_adb <= scan_cnt[7:0] + 8'd1;
                        end
                        if (scan_cnt >= LAT) begin
                            max_cnt <= new_max;
                            max_x   <= new_x;
                            sum     <= new_sum;
                        end
                        if (scan_cnt == SCAN_END) begin
                            state        <= DONE;
                            busy         <= 1'b0;
                            peak_x       <= new_x;
                            peak_cnt     <= new_max;
                            col_total    <= new_sum;
                            found        <= (new_max >= MIN_PEAK);
                            result_valid <= 1'b1;
                        end
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_col_hist_accum.sv
// Directed bench for col_hist_accum with a behavioural 256x8 dual-port RAM
// (1-cycle registered read, old data on same-edge read/write collision).
module tb_col_hist_accum;
    logic        clk = 1'b0;
    logic        rst_n, sof, eof, pix_valid, pix_hit;
    logic [7:0]  pix_x;
    logic        busy, result_valid, found;
    logic [7:0]  peak_x, peak_cnt;
    logic [15:0] col_total;
    logic        ram_cea, ram_wrea, ram_ceb;
    logic [7:0]  ram_ada, ram_dina, ram_adb, ram_doutb;

    logic [7:0]  mem [256];
    int          total = 0;
    int          bad = 0;
    int          rv_pulses = 0;
    logic [7:0]  r_px, r_pc;
    logic [15:0] r_tot;
    logic        r_found;

    always #5 clk = ~clk;

    col_hist_accum #(.MIN_PEAK(8'd4), .RAM_RD_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n), .sof(sof), .eof(eof),
        .pix_valid(pix_valid), .pix_x(pix_x), .pix_hit(pix_hit),
        .busy(busy), .result_valid(result_valid), .peak_x(peak_x),
        .peak_cnt(peak_cnt), .col_total(col_total), .found(found),
        .ram_cea(ram_cea), .ram_wrea(ram_wrea), .ram_ada(ram_ada),
        .ram_dina(ram_dina), .ram_ceb(ram_ceb), .ram_adb(ram_adb),
        .ram_doutb(ram_doutb)
    );

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'hA5;
        ram_doutb = 8'h00;
    end

    always @(posedge clk) begin
        if (ram_cea && ram_wrea) mem[ram_ada] <= ram_dina;
        if (ram_ceb) ram_doutb <= mem[ram_adb];
    end

    always @(negedge clk) if (result_valid === 1'b1) rv_pulses++;

    task automatic send_pix(input logic [7:0] x, input logic hit);
        pix_valid = 1'b1; pix_x = x; pix_hit = hit;
        @(negedge clk);
        pix_valid = 1'b0; pix_hit = 1'b0;
    endtask

    task automatic pulse_sof();
        sof = 1'b1;
        @(negedge clk);
        sof = 1'b0;
    endtask

    task automatic wait_accum(input string name);
        int n = 0;
        while (busy !== 1'b0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL %s clear_timeout: busy=%b required 0", name, busy);
        end
    endtask

    task automatic start_frame(input string name);
        pulse_sof();
        wait_accum(name);
    endtask

    task automatic finish_frame(input string name);
        int  n = 0;
        logic seen = 1'b0;
        eof = 1'b1;
        @(negedge clk);
        eof = 1'b0;
        while (!seen && n < 700) begin
            if (result_valid === 1'b1) begin
                seen = 1'b1;
                r_px = peak_x; r_pc = peak_cnt; r_tot = col_total; r_found = found;
            end else begin
                @(negedge clk);
                n++;
            end
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL %s result_timeout: result_valid never seen, required within 700 cycles", name);
        end else begin
            total++;
            if (n != 259) begin
                bad++;
                $display("FAIL %s latency: got %0d cycles after eof, required 259", name, n);
            end
            @(negedge clk);
            total++;
            if (result_valid !== 1'b0) begin
                bad++;
                $display("FAIL %s pulse_width: result_valid=%b one cycle later, required 0", name, result_valid);
            end
        end
        $display("frame %s: peak_x=%0d peak_cnt=%0d col_total=%0d found=%0d", name, r_px, r_pc, r_tot, r_found);
    endtask

    task automatic check_result(input string name, input logic [7:0] px, input logic [7:0] pc,
                                input logic [15:0] tot, input logic fnd);
        total++;
        if ({r_px, r_pc, r_tot, r_found} !== {px, pc, tot, fnd}) begin
            bad++;
            $display("FAIL %s result: got x=%0d cnt=%0d tot=%0d found=%b, required x=%0d cnt=%0d tot=%0d found=%b",
                     name, r_px, r_pc, r_tot, r_found, px, pc, tot, fnd);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; sof = 1'b0; eof = 1'b0; pix_valid = 1'b0; pix_hit = 1'b0; pix_x = 8'd0;
        repeat (3) @(negedge clk);
        total++;
        if ({busy, result_valid, peak_x, peak_cnt, col_total, found, ram_cea, ram_wrea,
             ram_ada, ram_dina, ram_ceb, ram_adb} !== 62'd0) begin
            bad++;
            $display("FAIL reset outputs: busy=%b rv=%b px=%0d pc=%0d tot=%0d wrea=%b ceb=%b, required all 0",
                     busy, result_valid, peak_x, peak_cnt, col_total, ram_wrea, ram_ceb);
        end
        rst_n = 1'b1;
        @(negedge clk);
        $display("reset released");
    endtask

    task automatic test_clear();
        int idx = 0;
        pulse_sof();
        while (ram_wrea === 1'b1 && idx < 300) begin
            total++;
            if (ram_cea !== 1'b1 || ram_ada !== idx[7:0] || ram_dina !== 8'd0 || busy !== 1'b1) begin
                bad++;
                $display("FAIL clear cycle %0d: cea=%b ada=%0d dina=%0d busy=%b, required 1/%0d/0/1",
                         idx, ram_cea, ram_ada, ram_dina, busy, idx[7:0]);
            end
            pix_valid = 1'b1; pix_hit = 1'b1; pix_x = idx[7:0];
            @(negedge clk);
            idx++;
        end
        pix_valid = 1'b0; pix_hit = 1'b0;
        total++;
        if (idx != 256) begin
            bad++;
            $display("FAIL clear length: got %0d write cycles, required 256", idx);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL clear accum_busy: busy=%b after clear, required 0", busy);
        end
        finish_frame("clear");
        check_result("clear", 8'd0, 8'd0, 16'd0, 1'b0);
    endtask

    task automatic test_tie();
        start_frame("tie");
        for (int i = 0; i < 5; i++) begin
            if (i < 3) send_pix(8'd10, 1'b1);
            @(negedge clk);
            send_pix(8'd200, 1'b1);
            @(negedge clk);
            send_pix(8'd50, 1'b1);
            @(negedge clk);
        end
        finish_frame("tie");
        check_result("tie", 8'd50, 8'd5, 16'd13, 1'b1);
        repeat (5) @(negedge clk);
        total++;
        if (peak_cnt !== 8'd5 || peak_x !== 8'd50) begin
            bad++;
            $display("FAIL tie hold: px=%0d pc=%0d after DONE, required 50/5", peak_x, peak_cnt);
        end
    endtask

    task automatic test_saturate();
        start_frame("saturate");
        pix_valid = 1'b1; pix_hit = 1'b1; pix_x = 8'd7;
        repeat (300) @(negedge clk);
        pix_valid = 1'b0; pix_hit = 1'b0;
        finish_frame("saturate");
        check_result("saturate", 8'd7, 8'd255, 16'd255, 1'b1);
    endtask

    task automatic test_back_to_back();
        start_frame("b2b");
        send_pix(8'd3, 1'b1);
        send_pix(8'd3, 1'b1);
        send_pix(8'd4, 1'b1);
        send_pix(8'd3, 1'b1);
        send_pix(8'd3, 1'b0);
        finish_frame("b2b");
        check_result("b2b", 8'd3, 8'd3, 16'd4, 1'b0);
        total++;
        if (mem[3] !== 8'd3 || mem[4] !== 8'd1) begin
            bad++;
            $display("FAIL b2b ram_counts: count3=%0d count4=%0d, required 3/1", mem[3], mem[4]);
        end
    endtask

    task automatic test_abort();
        int rv_before;
        start_frame("abort");
        send_pix(8'd9, 1'b1);
        send_pix(8'd9, 1'b1);
        send_pix(8'd9, 1'b1);
        eof = 1'b1;
        @(negedge clk);
        eof = 1'b0;
        repeat (100) @(negedge clk);
        rv_before = rv_pulses;
        pulse_sof();
        total++;
        if (ram_wrea !== 1'b1 || ram_ada !== 8'd0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL abort restart: wrea=%b ada=%0d busy=%b, required 1/0/1", ram_wrea, ram_ada, busy);
        end
        wait_accum("abort");
        total++;
        if (rv_pulses != rv_before) begin
            bad++;
            $display("FAIL abort no_result: %0d result pulses after abort, required 0", rv_pulses - rv_before);
        end
        send_pix(8'd9, 1'b1);
        @(negedge clk);
        send_pix(8'd9, 1'b1);
        finish_frame("abort");
        check_result("abort", 8'd9, 8'd2, 16'd2, 1'b0);
    endtask

    task automatic test_reset_mid();
        int rv_before;
        start_frame("rstmid");
        send_pix(8'd20, 1'b1);
        send_pix(8'd21, 1'b1);
        rst_n = 1'b0; pix_valid = 1'b1; pix_hit = 1'b1; pix_x = 8'd22;
        @(negedge clk);
        rst_n = 1'b1; pix_valid = 1'b0; pix_hit = 1'b0;
        total++;
        if ({busy, result_valid, peak_x, peak_cnt, col_total, found, ram_cea, ram_wrea,
             ram_ada, ram_dina, ram_ceb, ram_adb} !== 62'd0) begin
            bad++;
            $display("FAIL rstmid outputs: busy=%b px=%0d pc=%0d tot=%0d wrea=%b ada=%0d ceb=%b adb=%0d, required all 0",
                     busy, peak_x, peak_cnt, col_total, ram_wrea, ram_ada, ram_ceb, ram_adb);
        end
        rv_before = rv_pulses;
        eof = 1'b1;
        @(negedge clk);
        eof = 1'b0;
        for (int i = 0; i < 300; i++) begin
            total++;
            if (busy !== 1'b0) begin
                bad++;
                $display("FAIL rstmid idle: busy=%b %0d cycles after eof, required 0", busy, i);
                break;
            end
            @(negedge clk);
        end
        total++;
        if (rv_pulses != rv_before) begin
            bad++;
            $display("FAIL rstmid no_result: %0d result pulses, required 0", rv_pulses - rv_before);
        end
        $display("frame rstmid: reset mid-accumulate, eof ignored");
    endtask

    initial begin
        test_reset();
        test_clear();
        test_tie();
        test_saturate();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
